// File: rtl/nor_vector_sequencer.sv
// Drives the four two-input vectors onto a downstream NOR gate, holds each for
// HOLD cycles, checks the gate output against EXPECT and reports the results.
module nor_vector_sequencer #(
  parameter int unsigned HOLD   = 10,
  parameter logic [3:0]  EXPECT = 4'b0001
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       START,
  output logic       A,
  output logic       B,
  input  logic       X,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [2:0] ERR_CNT,
  output logic [3:0] FAIL_MASK
);

  localparam int unsigned HCNT_W  = 8;
  localparam int unsigned ERR_MAX = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          vidx, vidx_nxt;
  logic [HCNT_W-1:0]   hcnt, hcnt_nxt;
  logic                drain, drain_nxt;
  logic                a_nxt, b_nxt;
  logic                busy_nxt, done_nxt, pass_nxt;
  logic [2:0]          err_nxt;
  logic [3:0]          fail_nxt;
  logic                hold_end_c;
  logic                miss_c;

  assign hold_end_c = (hcnt == HCNT_W'(HOLD - 1));
  // Case inequality so an undriven or unknown gate output counts as a miss.
  assign miss_c     = (X !== EXPECT[vidx]);

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      vidx      <= 2'd0;
      hcnt      <= '0;
      drain     <= 1'b0;
      A         <= 1'b0;
      B         <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      PASS      <= 1'b0;
      ERR_CNT   <= 3'd0;
      FAIL_MASK <= 4'd0;
    end else begin
      state     <= state_nxt;
      vidx      <= vidx_nxt;
      hcnt      <= hcnt_nxt;
      drain     <= drain_nxt;
      A         <= a_nxt;
      B         <= b_nxt;
      BUSY      <= busy_nxt;
      DONE      <= done_nxt;
      PASS      <= pass_nxt;
      ERR_CNT   <= err_nxt;
      FAIL_MASK <= fail_nxt;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_nxt = state;
    vidx_nxt  = vidx;
    hcnt_nxt  = hcnt;
    drain_nxt = drain;
    a_nxt     = A;
    b_nxt     = B;
    busy_nxt  = BUSY;
    done_nxt  = DONE;
    pass_nxt  = PASS;
    err_nxt   = ERR_CNT;
    fail_nxt  = FAIL_MASK;

    case (state)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_nxt = S_DRIVE;
          vidx_nxt  = 2'd0;
          hcnt_nxt  = '0;
          drain_nxt = 1'b0;
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          err_nxt   = 3'd0;
          fail_nxt  = 4'd0;
        end
      end

      S_DRIVE: begin
        // A/B follow VIDX one cycle late, leaving HOLD-1 settle cycles per check.
        a_nxt = vidx[0];
        b_nxt = vidx[1];
        if (drain) begin
          state_nxt = S_DONE;
          vidx_nxt  = 2'd0;
          hcnt_nxt  = '0;
          drain_nxt = 1'b0;
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = (ERR_CNT == 3'd0);
        end else begin
          hcnt_nxt = hcnt + HCNT_W'(1);
          if (hold_end_c) begin
            hcnt_nxt = '0;
            if (miss_c) begin
              fail_nxt[vidx] = 1'b1;
              if (ERR_CNT != 3'(ERR_MAX)) begin
                err_nxt = ERR_CNT + 3'd1;
              end
            end
            if (vidx == 2'd3) begin
              drain_nxt = 1'b1;
            end else begin
              vidx_nxt = vidx + 2'd1;
            end
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nor_vector_sequencer.sv
// Directed bench for nor_vector_sequencer: drives a modelled NOR gate (or a
// faulty stand-in) on X and checks sequencing, timing and reported results.
module tb_nor_vector_sequencer;

  localparam int HOLD = 10;
  localparam int LAT  = 1 + 4 * HOLD;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       a, b, x;
  logic       busy, done, pass;
  logic [2:0] err_cnt;
  logic [3:0] fail_mask;

  int         n_cmp;
  int         n_bad;
  int         mode;   // 0 good NOR, 1 stuck-at-0, 2 stuck-at-1, 3 inverted
  logic       gate_x;

  nor_vector_sequencer #(.HOLD(HOLD), .EXPECT(4'b0001)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .START    (start),
    .A        (a),
    .B        (b),
    .X        (x),
    .BUSY     (busy),
    .DONE     (done),
    .PASS     (pass),
    .ERR_CNT  (err_cnt),
    .FAIL_MASK(fail_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign #1 gate_x = ~(a | b);

  always_comb begin
    case (mode)
      0:       x = gate_x;
      1:       x = 1'b0;
      2:       x = 1'b1;
      default: x = ~gate_x;
    endcase
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] outs();
    return {5'd0, a, b, busy, done, pass, err_cnt, fail_mask};
  endfunction

  // Pulse START, follow the run to DONE and check timing, vectors and results.
  task automatic run(input string tag, input int poke_at,
                     input logic [3:0] e_mask, input logic [2:0] e_err, input logic e_pass);
    int   lat;
    int   k;
    logic ab_ok;
    logic excl_ok;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_eq({tag, "_go"}, {11'd0, busy, done, pass, err_cnt == 3'd0, fail_mask == 4'd0},
             {11'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
    lat = 0; ab_ok = 1'b1; excl_ok = 1'b1;
    for (int j = 1; j <= 100; j++) begin
      @(posedge clk); #1;
      if (busy && done) excl_ok = 1'b0;
      if (done) begin
        lat = j;
        break;
      end
      k = (j - 1) / HOLD;
      if ({a, b} !== {k[0], k[1]}) ab_ok = 1'b0;
      start = (j == poke_at);
    end
    start = 1'b0;
    check_eq({tag, "_lat"}, 16'(lat), 16'(LAT));
    check_eq({tag, "_ab_seq"}, 16'(ab_ok), 16'd1);
    check_eq({tag, "_busy_done_excl"}, 16'(excl_ok), 16'd1);
    check_eq({tag, "_result"}, outs(), {5'd0, 1'b0, 1'b0, 1'b0, 1'b1, e_pass, e_err, e_mask});
  endtask

  initial begin
    int lat;
    n_cmp = 0; n_bad = 0; mode = 0;
    rst_n = 1'b0; start = 1'b0;
    #3;
    check_eq("reset_initial", outs(), 16'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_eq("idle_wait", outs(), 16'd0);

    run("good", 0, 4'b0000, 3'd0, 1'b1);
    repeat (3) @(posedge clk);
    #1 check_eq("done_hold", outs(), {5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'd0});

    // Asynchronous reset from DONE, mid-cycle
    #2 rst_n = 1'b0;
    #1 check_eq("reset_async", outs(), 16'd0);
    #1 rst_n = 1'b1;

    mode = 1;
    run("stuck0", 0, 4'b0001, 3'd1, 1'b0);
    mode = 2;
    run("stuck1", 0, 4'b1110, 3'd3, 1'b0);
    mode = 3;
    run("inverted", 0, 4'b1111, 3'd4, 1'b0);
    mode = 0;
    run("start_busy", 15, 4'b0000, 3'd0, 1'b1);

    // Reset during vector 2, with START held through the reset
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (25) @(posedge clk);
    #1 check_eq("mid_ab_vec2", {14'd0, a, b}, {14'd0, 1'b0, 1'b1});
    #2 rst_n = 1'b0; start = 1'b1;
    #1 check_eq("reset_midrun", outs(), 16'd0);
    repeat (2) @(posedge clk);
    #1 check_eq("start_in_reset", outs(), 16'd0);
    start = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_eq("idle_after_reset", outs(), 16'd0);
    run("after_reset", 0, 4'b0000, 3'd0, 1'b1);

    // START held high: back-to-back runs with a one-cycle DONE
    mode = 1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    for (int j = 1; j <= 100; j++) begin
      @(posedge clk); #1;
      if (done) begin lat = j; break; end
    end
    check_eq("held_lat1", 16'(lat), 16'(LAT));
    check_eq("held_res1", {12'd0, err_cnt == 3'd1, fail_mask == 4'b0001, pass, 1'b0},
             {12'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    mode = 0;
    @(posedge clk); #1;
    check_eq("held_done_1cyc", {14'd0, busy, done}, {14'd0, 1'b1, 1'b0});
    check_eq("held_cleared", {9'd0, err_cnt, fail_mask}, 16'd0);
    lat = 0;
    for (int j = 1; j <= 100; j++) begin
      @(posedge clk); #1;
      if (done) begin lat = j; break; end
    end
    start = 1'b0;
    check_eq("held_lat2", 16'(lat), 16'(LAT));
    check_eq("held_res2", outs(), {5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
